// File: rtl/handshake_prop_checker.sv
// Run-time checker: a request must be acknowledged one cycle later, and an interrupt aborts the attempt.
// Also counts seq_a+ ##1 seq_b matches; define HPC_COVER_EN to include the coverage logic.
module handshake_prop_checker #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             req,
    input  logic             ack,
    input  logic             intr,
    input  logic             seq_a,
    input  logic             seq_b,
    output logic             pass_o,
    output logic             fail_o,
    output logic             abort_o,
    output logic             err_sticky,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] abort_cnt,
    output logic             cov_hit,
    output logic [CNT_W-1:0] cov_cnt,
    output logic [CNT_W-1:0] run_len,
    output logic [CNT_W-1:0] max_run
);

    // Clear takes effect first, so an event landing on the clear edge reads as 1.
    function automatic logic [CNT_W-1:0] f_bump(input logic [CNT_W-1:0] v,
                                                input logic c, input logic inc);
        logic [CNT_W-1:0] b;
        b = c ? '0 : v;
        return (inc && !(&b)) ? b + CNT_W'(1) : b;
    endfunction

    logic             r_pend, r_pend_ab;
    logic             r_pass, r_fail, r_abort, r_err;
    logic [CNT_W-1:0] r_pass_cnt, r_fail_cnt, r_abort_cnt;
    logic             w_pass, w_fail, w_abort;

    always_comb begin
        w_abort = 1'b0;
        w_pass  = 1'b0;
        w_fail  = 1'b0;
        if (r_pend) begin
            if (r_pend_ab || intr) w_abort = 1'b1;
            else if (ack)          w_pass  = 1'b1;
            else                   w_fail  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend      <= 1'b0;
            r_pend_ab   <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_abort     <= 1'b0;
            r_err       <= 1'b0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_abort_cnt <= '0;
        end else begin
            r_pend      <= req && en;
            r_pend_ab   <= intr;
            r_pass      <= w_pass;
            r_fail      <= w_fail;
            r_abort     <= w_abort;
            r_err       <= w_fail || (r_err && !clr);
            r_pass_cnt  <= f_bump(r_pass_cnt,  clr, w_pass);
            r_fail_cnt  <= f_bump(r_fail_cnt,  clr, w_fail);
            r_abort_cnt <= f_bump(r_abort_cnt, clr, w_abort);
        end
    end

    assign pass_o     = r_pass;
    assign fail_o     = r_fail;
    assign abort_o    = r_abort;
    assign err_sticky = r_err;
    assign pass_cnt   = r_pass_cnt;
    assign fail_cnt   = r_fail_cnt;
    assign abort_cnt  = r_abort_cnt;

`ifdef HPC_COVER_EN
    logic             r_cov_hit;
    logic [CNT_W-1:0] r_cov_cnt, r_run_len, r_max_run;
    logic             w_hit;
    logic [CNT_W-1:0] w_max_base;

    always_comb begin
        w_hit      = en && seq_b && (r_run_len != '0);
        w_max_base = clr ? '0 : r_max_run;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cov_hit <= 1'b0;
            r_cov_cnt <= '0;
            r_run_len <= '0;
            r_max_run <= '0;
        end else begin
            r_cov_hit <= w_hit;
            r_cov_cnt <= f_bump(r_cov_cnt, clr, w_hit);
            if (en && seq_a) r_run_len <= f_bump(r_run_len, 1'b0, 1'b1);
            else             r_run_len <= '0;
            if (w_hit && (r_run_len > w_max_base)) r_max_run <= r_run_len;
            else                                   r_max_run <= w_max_base;
        end
    end

    assign cov_hit = r_cov_hit;
    assign cov_cnt = r_cov_cnt;
    assign run_len = r_run_len;
    assign max_run = r_max_run;
`else
    logic w_unused;
    assign w_unused = ^{seq_a, seq_b};
    assign cov_hit  = 1'b0;
    assign cov_cnt  = '0;
    assign run_len  = '0;
    assign max_run  = '0;
`endif

endmodule

// File: tb/tb_handshake_prop_checker.sv
// Scoreboard bench for handshake_prop_checker: stimulus queues hand-computed expectations per cycle,
// a negedge monitor compares them; a CNT_W=2 instance covers counter saturation.
module tb_handshake_prop_checker;

`ifdef HPC_COVER_EN
    localparam bit COV = 1'b1;
`else
    localparam bit COV = 1'b0;
`endif
    localparam logic [3:0] N = 4'b0000, P = 4'b1000, F = 4'b0100, A = 4'b0010, C = 4'b0001;

    logic clk = 1'b0, rst_n = 1'b0;
    logic en = 1'b0, clr = 1'b0, req = 1'b0, ack = 1'b0, intr = 1'b0, seq_a = 1'b0, seq_b = 1'b0;
    logic pass_o, fail_o, abort_o, err_sticky, cov_hit;
    logic [15:0] pass_cnt, fail_cnt, abort_cnt, cov_cnt, run_len, max_run;
    logic pass2, fail2, abort2, err2, hit2;
    logic [1:0] pcnt2, fcnt2, acnt2, ccnt2, rlen2, mrun2;

    typedef struct {
        int          cyc;
        logic [3:0]  pl;
        logic [15:0] pc, fc, ac, cc, mr, rl;
        logic        er;
        logic        chk2;
        logic [1:0]  p2;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0, n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    handshake_prop_checker #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .req(req), .ack(ack), .intr(intr),
        .seq_a(seq_a), .seq_b(seq_b), .pass_o(pass_o), .fail_o(fail_o), .abort_o(abort_o),
        .err_sticky(err_sticky), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .abort_cnt(abort_cnt),
        .cov_hit(cov_hit), .cov_cnt(cov_cnt), .run_len(run_len), .max_run(max_run));

    handshake_prop_checker #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .req(req), .ack(ack), .intr(intr),
        .seq_a(seq_a), .seq_b(seq_b), .pass_o(pass2), .fail_o(fail2), .abort_o(abort2),
        .err_sticky(err2), .pass_cnt(pcnt2), .fail_cnt(fcnt2), .abort_cnt(acnt2),
        .cov_hit(hit2), .cov_cnt(ccnt2), .run_len(rlen2), .max_run(mrun2));

    task chk(input string nm, input logic [15:0] a, input logic [15:0] e);
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, a, e);
        end
    endtask

    // Expected state at the negedge of cycle c; coverage fields are zero when coverage is compiled out.
    task ex(input int c, input logic [3:0] pl, input logic [15:0] pc, fc, ac, input logic er,
            input logic [15:0] cc, mr, rl, input logic chk2 = 1'b0, input logic [1:0] p2 = 2'd0);
        exp_t e;
        e.cyc = c;
        e.pl  = {pl[3:1], pl[0] & COV};
        e.pc  = pc; e.fc = fc; e.ac = ac; e.er = er;
        e.cc  = COV ? cc : 16'd0;
        e.mr  = COV ? mr : 16'd0;
        e.rl  = COV ? rl : 16'd0;
        e.chk2 = chk2; e.p2 = p2;
        q.push_back(e);
    endtask

    task drv(input logic e, r, k, i, c, a, b);
        en = e; req = r; ack = k; intr = i; clr = c; seq_a = a; seq_b = b;
        @(posedge clk);
        #1;
    endtask

    task idle(input int n);
        for (int i = 0; i < n; i++) drv(1, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [3:0] act;
        act = {pass_o, fail_o, abort_o, cov_hit};
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            chk("pulses",     {12'd0, act},        {12'd0, e.pl});
            chk("pass_cnt",   pass_cnt,            e.pc);
            chk("fail_cnt",   fail_cnt,            e.fc);
            chk("abort_cnt",  abort_cnt,           e.ac);
            chk("err_sticky", {15'd0, err_sticky}, {15'd0, e.er});
            chk("cov_cnt",    cov_cnt,             e.cc);
            chk("max_run",    max_run,             e.mr);
            chk("run_len",    run_len,             e.rl);
            if (e.chk2) chk("pass_cnt_w2", {14'd0, pcnt2}, {14'd0, e.p2});
        end else if (cyc > 0) begin
            chk("no_pulse", {12'd0, act}, 16'd0);
        end
    end

    initial begin
        int t0;
        // reset state
        t0 = cyc;
        ex(t0 + 1, N, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        ex(t0 + 2, N, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // single pass
        t0 = cyc;
        ex(t0 + 2, P, 1, 0, 0, 0, 0, 0, 0);
        ex(t0 + 3, N, 1, 0, 0, 0, 0, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 0);
        drv(1, 0, 1, 0, 0, 0, 0);
        idle(1);

        // fail, sticky error held, then cleared
        t0 = cyc;
        ex(t0 + 2, F, 1, 1, 0, 1, 0, 0, 0);
        ex(t0 + 4, N, 1, 1, 0, 1, 0, 0, 0);
        ex(t0 + 5, N, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 0);
        idle(3);
        drv(1, 0, 0, 0, 1, 0, 0);
        idle(1);

        // abort via intr at start, abort via intr at resolution, pass on clear edge
        t0 = cyc;
        ex(t0 + 2, A, 0, 0, 1, 0, 0, 0, 0);
        ex(t0 + 5, A, 0, 0, 2, 0, 0, 0, 0);
        ex(t0 + 8, P, 1, 0, 0, 0, 0, 0, 0);
        drv(1, 1, 0, 1, 0, 0, 0);
        idle(2);
        drv(1, 1, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 1, 0, 0, 0);
        idle(1);
        drv(1, 1, 0, 0, 0, 0, 0);
        drv(1, 0, 1, 0, 1, 0, 0);
        idle(1);

        // back-to-back passes, en=0 gating, resolution with en low
        t0 = cyc;
        for (int i = 0; i < 4; i++) ex(t0 + 3 + i, P, 16'(i + 1), 0, 0, 0, 0, 0, 0);
        ex(t0 + 8,  N, 0, 0, 0, 0, 0, 0, 0);
        ex(t0 + 12, N, 0, 0, 0, 0, 0, 0, 0);
        ex(t0 + 14, P, 1, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 1, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 0);
        drv(1, 1, 1, 0, 0, 0, 0);
        drv(1, 1, 1, 0, 0, 0, 0);
        drv(1, 1, 1, 0, 0, 0, 0);
        drv(1, 0, 1, 0, 0, 0, 0);
        idle(1);
        drv(1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) drv(0, 1, 1, 0, 0, 0, 0);
        drv(0, 0, 1, 0, 0, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 0);
        drv(0, 0, 1, 0, 0, 0, 0);
        idle(1);

        // coverage: a,a,a,b hit; lone b no hit; a then a+b hit, then b hit
        t0 = cyc;
        ex(t0 + 3,  N, 0, 0, 0, 0, 0, 0, 2);
        ex(t0 + 4,  N, 0, 0, 0, 0, 0, 0, 3);
        ex(t0 + 5,  C, 0, 0, 0, 0, 1, 3, 0);
        ex(t0 + 8,  N, 0, 0, 0, 0, 1, 3, 0);
        ex(t0 + 10, C, 0, 0, 0, 0, 2, 3, 2);
        ex(t0 + 11, C, 0, 0, 0, 0, 3, 3, 0);
        ex(t0 + 12, N, 0, 0, 0, 0, 3, 3, 0);
        drv(1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) drv(1, 0, 0, 0, 0, 1, 0);
        drv(1, 0, 0, 0, 0, 0, 1);
        idle(2);
        drv(1, 0, 0, 0, 0, 0, 1);
        drv(1, 0, 0, 0, 0, 1, 0);
        drv(1, 0, 0, 0, 0, 1, 1);
        drv(1, 0, 0, 0, 0, 0, 1);
        idle(1);

        // reset in the middle of a pending attempt
        t0 = cyc;
        ex(t0 + 2, P, 1, 0, 0, 0, 3, 3, 0);
        ex(t0 + 4, N, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        ex(t0 + 5, N, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drv(1, 1, 0, 0, 0, 0, 0);
        drv(1, 0, 1, 0, 0, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        drv(1, 0, 1, 0, 0, 0, 0);
        rst_n = 1'b1;
        idle(2);

        // five passes: 16-bit counter reaches 5, 2-bit counter saturates at 3
        t0 = cyc;
        for (int i = 0; i < 5; i++)
            ex(t0 + 2 + i, P, 16'(i + 1), 0, 0, 0, 0, 0, 0, 1, (i < 3) ? 2'(i + 1) : 2'd3);
        drv(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drv(1, 1, 1, 0, 0, 0, 0);
        drv(1, 0, 1, 0, 0, 0, 0);
        idle(4);

        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
